// File: rtl/adder_check_pkg.sv
// Shared types and constants for the adder response checker.
package adder_check_pkg;

  localparam int unsigned ERR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of a/b pairs in a full exhaustive sweep: 2^(2*w).
  function automatic int unsigned total_vectors(input int unsigned w);
    return 32'd1 << (2 * w);
  endfunction

endpackage

// File: rtl/adder_checker_sweep_tracker.sv
// Order checker for the exhaustive generator sweep (a fastest, b on a wrap).
// Present only when ADDER_CHECKER_SEQ_EN is defined.
`ifdef ADDER_CHECKER_SEQ_EN
module sweep_tracker #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             seq_err,
  output logic             viol_c
);

  logic             first_q;
  logic [width-1:0] prev_a;
  logic [width-1:0] prev_b;
  logic [width-1:0] exp_a_c;
  logic [width-1:0] exp_b_c;

  // Next pair in sweep order, derived from the last vector actually seen.
  assign exp_a_c = prev_a + width'(1);
  assign exp_b_c = (prev_a == '1) ? prev_b + width'(1) : prev_b;
  assign viol_c  = en && (first_q ? ((a != '0) || (b != '0))
                                  : ((a != exp_a_c) || (b != exp_b_c)));

  // Track the previous vector and hold a sticky order-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b1;
      prev_a  <= '0;
      prev_b  <= '0;
      seq_err <= 1'b0;
    end else if (clear) begin
      first_q <= 1'b1;
      prev_a  <= '0;
      prev_b  <= '0;
      seq_err <= 1'b0;
    end else if (en) begin
      first_q <= 1'b0;
      prev_a  <= a;
      prev_b  <= b;
      if (viol_c) seq_err <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/adder_checker.sv
// Response checker for the ripple-carry adder: compares {cout,sum} against
// a+b+cin over a full exhaustive sweep and reports pass/fail.
// Optional build macro: ADDER_CHECKER_SEQ_EN (adds sweep-order checking and
// the seq_err output).
module adder_checker
  import adder_check_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 valid,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  input  logic                 cin,
  input  logic [width-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*width:0]     vec_count,
  output logic [ERR_W-1:0]     err_count,
  output logic [width-1:0]     first_err_a,
  output logic [width-1:0]     first_err_b
`ifdef ADDER_CHECKER_SEQ_EN
  ,
  output logic                 seq_err
`endif
);

  localparam int unsigned VCW = 2 * width + 1;
  localparam logic [VCW-1:0] TOTAL = VCW'(total_vectors(width));

  state_t           state;

  // Stage-1 sample register
  logic             s1_valid;
  logic [width-1:0] s1_a;
  logic [width-1:0] s1_b;
  logic             s1_cin;
  logic [width-1:0] s1_sum;
  logic             s1_cout;

  logic [width:0]   exp_c;
  logic             cmp_en_c;
  logic             mismatch_c;
  logic             last_c;
  logic [ERR_W-1:0] err_next_c;
  logic             seq_bad_c;

  // Stage-2 compare against a full-width reference sum
  assign exp_c      = (width+1)'(s1_a) + (width+1)'(s1_b) + (width+1)'(s1_cin);
  assign cmp_en_c   = (state == RUN) && s1_valid && !start;
  assign mismatch_c = cmp_en_c && ({s1_cout, s1_sum} != exp_c);
  assign err_next_c = (mismatch_c && (err_count != '1)) ? err_count + ERR_W'(1)
                                                        : err_count;
  assign last_c     = cmp_en_c && ((vec_count + VCW'(1)) == TOTAL);

`ifdef ADDER_CHECKER_SEQ_EN
  logic seq_viol_c;

  // Order check runs on exactly the vectors that are compared
  sweep_tracker #(.width(width)) u_sweep_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .en      (cmp_en_c),
    .a       (s1_a),
    .b       (s1_b),
    .seq_err (seq_err),
    .viol_c  (seq_viol_c)
  );

  // Include a violation on the final vector in the verdict
  assign seq_bad_c = seq_err || seq_viol_c;
`else
  assign seq_bad_c = 1'b0;
`endif

  // Control FSM, sample pipeline, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      vec_count   <= '0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_cin      <= 1'b0;
      s1_sum      <= '0;
      s1_cout     <= 1'b0;
    end else if (start) begin
      // Restart from any state; a sample arriving with start is dropped
      state       <= RUN;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      vec_count   <= '0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
      s1_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s1_valid <= 1'b0;
        end
        RUN: begin
          s1_valid <= valid;
          s1_a     <= a;
          s1_b     <= b;
          s1_cin   <= cin;
          s1_sum   <= sum;
          s1_cout  <= cout;
          if (cmp_en_c) begin
            vec_count <= vec_count + VCW'(1);
            err_count <= err_next_c;
            // err_count only reads zero before the first mismatch
            if (mismatch_c && (err_count == '0)) begin
              first_err_a <= s1_a;
              first_err_b <= s1_b;
            end
          end
          if (last_c) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (err_next_c == '0) && !seq_bad_c;
            s1_valid <= 1'b0;
          end
        end
        DONE: begin
          s1_valid <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          s1_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// Randomized self-checking bench for adder_checker (width = 4).
module tb_adder_checker;

  localparam int unsigned W  = 4;
  localparam int unsigned NV = 1 << (2 * W);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           valid;
  logic [W-1:0]   a, b, sum;
  logic           cin, cout;
  logic           busy, done, pass;
  logic [2*W:0]   vec_count;
  logic [15:0]    err_count;
  logic [W-1:0]   first_err_a, first_err_b;
`ifdef ADDER_CHECKER_SEQ_EN
  logic           seq_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model of what the checker should report for the current sweep
  int        m_vec;
  int        m_err;
  int        m_fa;
  int        m_fb;
  bit        m_seq;

  always #5 clk = ~clk;

  adder_checker #(.width(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .valid       (valid),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .vec_count   (vec_count),
    .err_count   (err_count),
    .first_err_a (first_err_a),
    .first_err_b (first_err_b)
`ifdef ADDER_CHECKER_SEQ_EN
    ,
    .seq_err     (seq_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_vec = 0;
    m_err = 0;
    m_fa  = 0;
    m_fb  = 0;
    m_seq = 1'b0;
  endtask

  task automatic do_start(input bit with_valid);
    start = 1'b1;
    valid = with_valid;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'b0;
    {cout, sum} = (W+1)'(int'(a) + int'(b));
    tick();
    start = 1'b0;
    valid = 1'b0;
    model_clear();
  endtask

  // Present one vector; the adder response is a correct sum unless a fault is asked for
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                      input bit f_sum0, input bit f_cout0, input bit f_rand);
    int         e;
    logic [W:0] r;
    e = int'(va) + int'(vb) + int'(vcin);
    r = (W+1)'(e);
    if (f_sum0)  r[0] = ~r[0];
    if (f_cout0) r[W] = 1'b0;
    if (f_rand)  r = r ^ (W+1)'($urandom_range(1, (1 << (W+1)) - 1));
    a = va; b = vb; cin = vcin; {cout, sum} = r; valid = 1'b1;
    tick();
    valid = 1'b0;
    if (m_vec < NV) begin
      m_vec++;
      if (int'(r) != e) begin
        if (m_err == 0) begin
          m_fa = int'(va);
          m_fb = int'(vb);
        end
        if (m_err < 65535) m_err++;
      end
    end
  endtask

  // mode: 0 clean, 1 sum bit0 fault at (3,5), 2 cout stuck 0 at (15,1), 3 random faults
  task automatic sweep(input int mode, input bit rnd);
    for (int idx = 0; idx < NV; idx++) begin
      logic [W-1:0] va, vb;
      logic         vc;
      va = W'(idx % (1 << W));
      vb = W'(idx / (1 << W));
      vc = rnd ? 1'($urandom) : 1'b0;
      if (rnd && ($urandom_range(0, 3) == 0)) tick();
      send(va, vb, vc,
           (mode == 1) && (va == 3) && (vb == 5),
           (mode == 2) && (va == 15) && (vb == 1),
           (mode == 3) && ($urandom_range(0, 15) == 0));
      if (mode == 0 && !rnd && idx == 0) check("latency_edge1", 32'(vec_count), 32'd0);
      if (mode == 0 && !rnd && idx == 1) check("latency_edge2", 32'(vec_count), 32'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) tick();
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_vec"},  32'(vec_count),   32'(m_vec));
    check({tag, "_err"},  32'(err_count),   32'(m_err));
    check({tag, "_fa"},   32'(first_err_a), 32'(m_fa));
    check({tag, "_fb"},   32'(first_err_b), 32'(m_fb));
    check({tag, "_pass"}, 32'(pass),        32'((m_err == 0) && !m_seq));
    check({tag, "_busy"}, 32'(busy),        32'd0);
`ifdef ADDER_CHECKER_SEQ_EN
    check({tag, "_seq"},  32'(seq_err),     32'(m_seq));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy),        32'd0);
    check({tag, "_done"}, 32'(done),        32'd0);
    check({tag, "_pass"}, 32'(pass),        32'd0);
    check({tag, "_vec"},  32'(vec_count),   32'd0);
    check({tag, "_err"},  32'(err_count),   32'd0);
    check({tag, "_fa"},   32'(first_err_a), 32'd0);
    check({tag, "_fb"},   32'(first_err_b), 32'd0);
`ifdef ADDER_CHECKER_SEQ_EN
    check({tag, "_seq"},  32'(seq_err),     32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
    model_clear();
    #12;
    check_zero("reset");
    rst = 1'b0;
    tick();

    // valid in IDLE is ignored
    for (int i = 0; i < 3; i++) send(W'(i), W'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("idle_ignore_vec", 32'(vec_count), 32'd0);
    check("idle_ignore_busy", 32'(busy), 32'd0);
    model_clear();

    // Clean full sweep
    do_start(1'b0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    sweep(0, 1'b0);
    wait_done("clean");
    check_result("clean");

    // Vectors after DONE are ignored and the verdict holds
    for (int i = 0; i < 3; i++) send(W'(i), W'(0), 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_done_vec", 32'(vec_count), NV);
    check("post_done_err", 32'(err_count), 32'd0);
    check("post_done_hold", 32'(done), 32'd1);

    // Sum bit 0 fault at a=3, b=5
    do_start(1'b0);
    sweep(1, 1'b0);
    wait_done("sum0");
    check_result("sum0");

    // Carry-out forced low at a=15, b=1
    do_start(1'b0);
    sweep(2, 1'b0);
    wait_done("cout0");
    check_result("cout0");

    // Randomized carry-in, gaps and faults
    for (int rep = 0; rep < 2; rep++) begin
      do_start(1'b0);
      sweep(3, 1'b1);
      wait_done("rand");
      check_result("rand");
    end

    // Asynchronous reset mid-sweep, then a fresh sweep
    do_start(1'b0);
    for (int idx = 0; idx < 100; idx++)
      send(W'(idx % (1 << W)), W'(idx / (1 << W)), 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_zero("rst_async");
    tick();
    rst = 1'b0;
    tick(); tick();
    check("rst_idle_busy", 32'(busy), 32'd0);
    check("rst_idle_vec", 32'(vec_count), 32'd0);
    do_start(1'b0);
    sweep(0, 1'b1);
    wait_done("after_rst");
    check_result("after_rst");

    // start together with valid mid-sweep: that sample and the in-flight one are dropped
    do_start(1'b0);
    for (int idx = 0; idx < 50; idx++)
      send(W'(idx % (1 << W)), W'(idx / (1 << W)), 1'b0, 1'b0, 1'b0, (idx == 49));
    do_start(1'b1);
    tick();
    check("restart_vec", 32'(vec_count), 32'd0);
    check("restart_err", 32'(err_count), 32'd0);
    sweep(0, 1'b0);
    wait_done("restart");
    check_result("restart");

`ifdef ADDER_CHECKER_SEQ_EN
    // Skip vector a=7, b=0 and pad with the wrapped pair to reach TOTAL
    do_start(1'b0);
    for (int idx = 0; idx < NV; idx++) begin
      if (idx == 7) continue;
      send(W'(idx % (1 << W)), W'(idx / (1 << W)), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    send(W'(0), W'(0), 1'b0, 1'b0, 1'b0, 1'b0);
    m_seq = 1'b1;
    wait_done("seq_skip");
    check_result("seq_skip");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_checker.md
# adder_checker

- Synthesizable response checker for the ripple-carry adder, sitting on the adder's output side opposite the exhaustive stimulus generator.
- Samples each presented vector (a, b, cin, sum, cout) and compares {cout, sum} against a reference a + b + cin.
- Counts vectors and mismatches, captures the first failing operands, and reports pass/fail once the full 2^(2·width) sweep has been checked.

## Interface
- width, 8, operand width; must match the adder under test
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; clears all state and begins a sweep
- valid  in  1  current a/b/cin/sum/cout form a vector to check
- a, b  in  width  adder operands
- cin  in  1  adder carry-in
- sum  in  width  adder sum under test
- cout  in  1  adder carry-out under test
- busy  out  1  high while in RUN
- done  out  1  high while in DONE
- pass  out  1  valid when done; 1 iff err_count == 0
- vec_count  out  2·width+1  vectors checked in the current sweep
- err_count  out  16  mismatches; saturates at 16'hFFFF
- first_err_a, first_err_b  out  width  operands of the first mismatch; 0 if none

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE. All outputs reset to 0.
- IDLE: valid is ignored. start moves to RUN and clears counters, first_err_*, and the pipeline.
- RUN: each valid cycle registers a sample into stage 1. The following cycle compares it:
  - expected = {1'b0,a} + {1'b0,b} + cin, width+1 bits, no truncation
  - mismatch when {cout,sum} != expected
- Every compared sample increments vec_count. A mismatch increments err_count (saturating).
- On the first mismatch of a sweep, first_err_a and first_err_b latch and hold until the next start.
- When vec_count reaches TOTAL = 2^(2·width), move to DONE; samples after that are ignored.
- DONE: done=1 and pass=(err_count==0); both hold until the next start or rst.
- start in RUN or DONE restarts: counters clear and any in-flight stage-1 sample is discarded.
- start and valid in the same cycle: the sample is discarded; checking begins the following cycle.
- valid low in RUN: no count change. Gaps are allowed.

## Timing
- Sample at edge N; its effect on vec_count, err_count and first_err_* is visible after edge N+1 (latency 2 edges).
- busy rises the cycle after start. done rises the cycle after the TOTAL-th compare.
- rst mid-sweep: all outputs return to 0 asynchronously and the checker stays in IDLE until start.
- No backpressure: the checker accepts valid every cycle.

## Configuration
- ADDER_CHECKER_SEQ_EN defined: also checks that vectors arrive in generator sweep order.
  - The first vector must be a=0, b=0.
  - a increments mod 2^width each vector.
  - b increments only when the previous a was all ones, otherwise holds.
  - Each order violation raises the seq_err output (1 bit, sticky until start). When set, pass=0.
- Not defined: the seq_err port is absent and order is not checked.

## Structure
- Package adder_check_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - ERR_W = 16
  - function total_vectors(width) returning 2^(2·width)
- Optional sub-module sweep_tracker implements the order check. It is instantiated only under ADDER_CHECKER_SEQ_EN.

## Test plan
- Correct model, width=4: start, then sweep all 256 a/b pairs with cin=0 -> done after 256 compares; pass=1; err_count=0; vec_count=256.
- Fault at sum bit 0 when a=3, b=5 -> err_count=1, first_err_a=3, first_err_b=5, pass=0 at done.
- Carry check, width=4: a=15, b=1, cin=0 must give sum=0, cout=1 (no mismatch). Forcing cout=0 gives err_count=1.
- Assert rst at vector 100, then start again -> all outputs 0 after rst; the new sweep completes with vec_count=256.
- start issued mid-sweep together with valid -> that sample is not counted; counters restart at 0.
- ADDER_CHECKER_SEQ_EN, skip vector a=7 -> seq_err=1 sticky and pass=0 at done even with err_count=0.
